// File: rtl/musicbox_audio_pkg.sv
// Shared audio-path types and constants for the music box tone blocks.
//   sample_t       : 8-bit unsigned audio sample, midscale 128
//   cross_state_t  : hysteretic zero-crossing detector state
//   SAMPLE_RATE_HZ : audio sample rate; a gate of this many samples is 1 s
//   FREQ_W         : width of the frequency result (crossings per window)
package musicbox_audio_pkg;

  typedef logic [7:0] sample_t;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_LOW     = 2'd1,
    ST_HIGH    = 2'd2
  } cross_state_t;

  localparam int SAMPLE_RATE_HZ = 32000;
  localparam int FREQ_W         = 14;

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

endpackage

// File: rtl/tone_frequency_meter_peak_tracker.sv
// Running maximum / minimum of the valid samples in the current window.
//   CLK_32KHz   : clock
//   reset       : asynchronous, active-high
//   sampleValid : sample is valid this cycle
//   sample      : unsigned sample
//   restart     : drop the running extremes (window end or clear); wins over sampleValid
//   runMax      : largest sample since the last restart (0 until the first valid sample)
//   runMin      : smallest sample since the last restart (255 until the first valid sample)
module peak_tracker
  import musicbox_audio_pkg::*;
(
  input  logic    CLK_32KHz,
  input  logic    reset,
  input  logic    sampleValid,
  input  sample_t sample,
  input  logic    restart,
  output sample_t runMax,
  output sample_t runMin
);

  always_ff @(posedge CLK_32KHz or posedge reset) begin
    if (reset) begin
      runMax <= 8'd0;
      runMin <= 8'd255;
    end else if (restart) begin
      runMax <= 8'd0;
      runMin <= 8'd255;
    end else if (sampleValid) begin
      if (sample > runMax) runMax <= sample;
      if (sample < runMin) runMin <= sample;
    end
  end

endmodule

// File: rtl/tone_frequency_meter.sv
// Tone frequency meter: counts hysteretic midscale rising crossings of the
// incoming sample stream over a gate of GATE_SAMPLES valid samples and reports
// per window the crossing count (Hz at a 1 s gate), the peak-to-peak amplitude
// and a signal-present flag.
//   CLK_32KHz         : sole clock
//   reset             : asynchronous, active-high
//   clear             : synchronous window restart; result outputs are kept
//   sampleValid       : inputSample is valid this cycle
//   inputSample       : unsigned sample, midscale 128
//   measuredFrequency : rising crossings in the last completed window
//   peakToPeak        : max - min of the last completed window
//   signalPresent     : last window had peakToPeak >= MIN_P2P and a nonzero count
//   measurementValid  : one-cycle pulse when the three results update
//   cross_state       : crossing detector state, for observation only
//
// Input handshake: there is no back-pressure. A sample is consumed on every
// rising clock edge where sampleValid=1; when sampleValid=0 the gate counter,
// crossing detector and min/max all hold.
module tone_frequency_meter
  import musicbox_audio_pkg::*;
#(
  parameter int GATE_SAMPLES = SAMPLE_RATE_HZ,
  parameter int MIDSCALE     = 128,
  parameter int HYSTERESIS   = 8,
  parameter int MIN_P2P      = 16
) (
  input  logic              CLK_32KHz,
  input  logic              reset,
  input  logic              clear,
  input  logic              sampleValid,
  input  sample_t           inputSample,
  output logic [FREQ_W-1:0] measuredFrequency,
  output sample_t           peakToPeak,
  output logic              signalPresent,
  output logic              measurementValid,
  output cross_state_t      cross_state
);

  localparam int                GATE_W    = (GATE_SAMPLES > 1) ? $clog2(GATE_SAMPLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_SAMPLES - 1);
  localparam sample_t           HI_TH     = sample_t'(MIDSCALE + HYSTERESIS);
  localparam sample_t           LO_TH     = sample_t'(MIDSCALE - HYSTERESIS);
  localparam sample_t           P2P_MIN   = sample_t'(MIN_P2P);

  logic [GATE_W-1:0] gate_count;
  logic [FREQ_W-1:0] cross_count;
  logic [FREQ_W-1:0] cross_next;
  cross_state_t      state;
  sample_t           run_max;
  sample_t           run_min;
  sample_t           max_next;
  sample_t           min_next;
  sample_t           p2p_next;
  logic              at_high;
  logic              at_low;
  logic              rise;
  logic              final_sample;

  // The final sample of a window must be included in the latched results,
  // so the results are taken from the values the trackers would hold after
  // this sample rather than from the registers themselves.
  always_comb begin
    at_high      = (inputSample >= HI_TH);
    at_low       = (inputSample <= LO_TH);
    final_sample = sampleValid && (gate_count == GATE_LAST);
    rise         = sampleValid && (state == ST_LOW) && at_high;
    cross_next   = (rise && (cross_count != FREQ_MAX)) ? cross_count + 1'b1 : cross_count;
    max_next     = (inputSample > run_max) ? inputSample : run_max;
    min_next     = (inputSample < run_min) ? inputSample : run_min;
    // With at least one sample seen, max_next >= min_next, so no wrap.
    p2p_next     = max_next - min_next;
  end

  peak_tracker u_peak_tracker (
    .CLK_32KHz   (CLK_32KHz),
    .reset       (reset),
    .sampleValid (sampleValid),
    .sample      (inputSample),
    .restart     (clear | final_sample),
    .runMax      (run_max),
    .runMin      (run_min)
  );

  always_ff @(posedge CLK_32KHz or posedge reset) begin
    if (reset) begin
      gate_count        <= '0;
      cross_count       <= '0;
      state             <= ST_UNKNOWN;
      measuredFrequency <= '0;
      peakToPeak        <= '0;
      signalPresent     <= 1'b0;
      measurementValid  <= 1'b0;
    end else begin
      measurementValid <= 1'b0;
      if (clear) begin
        // Discards the window in progress, even on its final sample.
        gate_count  <= '0;
        cross_count <= '0;
        state       <= ST_UNKNOWN;
      end else if (sampleValid) begin
        // The detector state carries across window boundaries so a tone
        // that is mid-cycle at the boundary is not miscounted.
        case (state)
          ST_UNKNOWN: begin
            if (at_high)     state <= ST_HIGH;
            else if (at_low) state <= ST_LOW;
          end
          ST_LOW:  if (at_high) state <= ST_HIGH;
          ST_HIGH: if (at_low)  state <= ST_LOW;
          default: state <= ST_UNKNOWN;
        endcase

        if (final_sample) begin
          gate_count        <= '0;
          cross_count       <= '0;
          measuredFrequency <= cross_next;
          peakToPeak        <= p2p_next;
          signalPresent     <= (p2p_next >= P2P_MIN) && (cross_next != '0);
          measurementValid  <= 1'b1;
        end else begin
          gate_count  <= gate_count + 1'b1;
          cross_count <= cross_next;
        end
      end
    end
  end

  assign cross_state = state;

endmodule

// File: tb/tb_tone_frequency_meter.sv
// Self-checking bench for tone_frequency_meter, run with a 640-sample gate
// so every scenario completes in a few thousand clocks.
module tb_tone_frequency_meter;
  import musicbox_audio_pkg::*;

  localparam int G    = 640;
  localparam int HI   = 136;
  localparam int LO   = 120;
  localparam int MINP = 16;

  // ---------------- clock / reset ----------------
  logic    clk   = 1'b0;
  logic    reset = 1'b1;
  logic    clear = 1'b0;
  logic    valid = 1'b0;
  sample_t smp   = 8'd128;

  logic [FREQ_W-1:0] freq;
  sample_t           p2p;
  logic              sp;
  logic              mv;
  cross_state_t      st;

  always #5 clk = ~clk;

  tone_frequency_meter #(
    .GATE_SAMPLES (G),
    .MIDSCALE     (128),
    .HYSTERESIS   (8),
    .MIN_P2P      (MINP)
  ) dut (
    .CLK_32KHz         (clk),
    .reset             (reset),
    .clear             (clear),
    .sampleValid       (valid),
    .inputSample       (smp),
    .measuredFrequency (freq),
    .peakToPeak        (p2p),
    .signalPresent     (sp),
    .measurementValid  (mv),
    .cross_state       (st)
  );

  int vectors = 0;
  int errors  = 0;

  // ---------------- behavioural model ----------------
  // Keeps every valid sample since the last clear/reset. At each window end
  // the results are computed from the window's samples: a sample at or above
  // HI is a counted crossing when the most recent earlier out-of-band sample
  // was at or below LO.
  sample_t           hist[$];
  int                m_gate  = 0;
  logic [FREQ_W-1:0] m_freq  = '0;
  sample_t           m_p2p   = '0;
  logic              m_sp    = 1'b0;
  logic              m_pulse = 1'b0;

  function automatic int rises_in_last(input int n);
    int cnt = 0;
    for (int i = hist.size() - n; i < hist.size(); i++) begin
      if (int'(hist[i]) >= HI) begin
        for (int j = i - 1; j >= 0; j--) begin
          if (int'(hist[j]) >= HI || int'(hist[j]) <= LO) begin
            if (int'(hist[j]) <= LO) cnt++;
            break;
          end
        end
      end
    end
    return cnt;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      m_gate  = 0;
      m_freq  = '0;
      m_p2p   = '0;
      m_sp    = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (clear) begin
        hist.delete();
        m_gate = 0;
      end else if (valid) begin
        hist.push_back(smp);
        m_gate++;
        if (m_gate == G) begin
          int r;
          int mx;
          int mn;
          r  = rises_in_last(G);
          mx = 0;
          mn = 255;
          for (int i = hist.size() - G; i < hist.size(); i++) begin
            if (int'(hist[i]) > mx) mx = int'(hist[i]);
            if (int'(hist[i]) < mn) mn = int'(hist[i]);
          end
          m_freq  = FREQ_W'((r > 16383) ? 16383 : r);
          m_p2p   = sample_t'(mx - mn);
          m_sp    = ((mx - mn) >= MINP) && (r != 0);
          m_pulse = 1'b1;
          m_gate  = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    vectors++;
    if ({freq, p2p, sp, mv} !== {m_freq, m_p2p, m_sp, m_pulse}) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: freq=%0d p2p=%0d sp=%0b pulse=%0b, required freq=%0d p2p=%0d sp=%0b pulse=%0b",
               $time, freq, p2p, sp, mv, m_freq, m_p2p, m_sp, m_pulse);
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_results(input string name, input int e_mv, input int e_freq,
                               input int e_p2p, input int e_sp);
    check({name, ".pulse"}, int'(mv),   e_mv);
    check({name, ".freq"},  int'(freq), e_freq);
    check({name, ".p2p"},   int'(p2p),  e_p2p);
    check({name, ".sp"},    int'(sp),   e_sp);
  endtask

  // ---------------- drivers ----------------
  int unsigned phase = 0;

  function automatic sample_t sine_at(input int unsigned ph);
    real x;
    x = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 65536.0);
    return sample_t'(int'(x));
  endfunction

  task automatic drive(input logic v, input sample_t s, input logic c);
    valid = v;
    smp   = s;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    drive(1'b0, 8'd128, 1'b1);
    clear = 1'b0;
  endtask

  task automatic drive_alt(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, (i % 2 == 1) ? 8'd255 : 8'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_results("reset", 0, 0, 0, 0);
    check("reset.state", int'(st), int'(ST_UNKNOWN));
    reset = 1'b0;
    drive(1'b0, 8'd128, 1'b0);

    // 1000 Hz sine, 32 samples per period: first window starts in the
    // unknown state so its first rise is not counted.
    phase = 0;
    for (int i = 0; i < G; i++) begin
      drive(1'b1, sine_at(phase), 1'b0);
      phase = (phase + 2048) % 65536;
    end
    check_results("sine_w1", 1, 19, 254, 1);
    for (int i = 0; i < G; i++) begin
      drive(1'b1, sine_at(phase), 1'b0);
      phase = (phase + 2048) % 65536;
    end
    check_results("sine_w2", 1, 20, 254, 1);

    // Constant midscale.
    do_clear();
    for (int i = 0; i < G; i++) drive(1'b1, 8'd128, 1'b0);
    check_results("const128", 1, 0, 0, 0);

    // Square wave inside the hysteresis band.
    do_clear();
    for (int i = 0; i < G; i++) drive(1'b1, (i % 32 < 16) ? 8'd133 : 8'd123, 1'b0);
    check_results("inband_sq", 1, 0, 10, 0);

    // Full-scale alternation: a rise on every other sample.
    do_clear();
    drive_alt(G);
    check_results("alt", 1, G / 2, 255, 1);

    // Sine advanced per clock, valid every other clock.
    do_clear();
    phase = 0;
    for (int k = 0; k < 2 * G - 1; k++) begin
      drive((k % 2) == 0, sine_at(phase), 1'b0);
      phase = (phase + 2048) % 65536;
    end
    check_results("half_rate", 1, 39, 254, 1);

    // Reset mid-window.
    do_clear();
    drive_alt(300);
    reset = 1'b1;
    #1;
    check_results("midreset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_alt(G - 1);
    check("post_reset.early_pulse", int'(mv), 0);
    drive(1'b1, 8'd255, 1'b0);
    check_results("post_reset", 1, G / 2, 255, 1);

    // clear coinciding with the final sample discards that window.
    do_clear();
    for (int i = 0; i < G - 1; i++) drive(1'b1, 8'd200, 1'b0);
    drive(1'b1, 8'd200, 1'b1);
    check_results("clear_final", 0, G / 2, 255, 1);
    for (int i = 0; i < G; i++) drive(1'b1, 8'd200, 1'b0);
    check_results("after_clear", 1, 0, 0, 0);

    drive(1'b0, 8'd128, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
